// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the map/collision logic, the game sequencer and the man block.
// master : the environment side (drives frame_clk and the level events, observes strobes/status)
// slave  : game_flow_ctrl (observes the events, drives the strobes/status)
// Signals: frame_clk, start, hazard_hit, checkpoint_hit, goal_hit (to sequencer);
//          dead, check, restart, freeze, lives, game_state, death_count (from sequencer).
interface game_flow_ctrl_if #(
  parameter int LIVES_W = 3
);
  logic               frame_clk;
  logic               start;
  logic               hazard_hit;
  logic               checkpoint_hit;
  logic               goal_hit;
  logic               dead;
  logic               check;
  logic               restart;
  logic               freeze;
  logic [LIVES_W-1:0] lives;
  logic [2:0]         game_state;
  logic [7:0]         death_count;

  modport master (
    output frame_clk, start, hazard_hit, checkpoint_hit, goal_hit,
    input  dead, check, restart, freeze, lives, game_state, death_count
  );

  modport slave (
    input  frame_clk, start, hazard_hit, checkpoint_hit, goal_hit,
    output dead, check, restart, freeze, lives, game_state, death_count
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: player-sprite game sequencer (IDLE/PLAY/DYING/RESPAWN/OVER/WIN).
// Ports:
//   Clk      system clock
//   Reset_n  asynchronous active-low reset
//   bus      game_flow_ctrl_if.slave: frame_clk, start, hazard_hit, checkpoint_hit, goal_hit in;
//            dead/check/restart one-Clk strobes, freeze, lives, game_state, death_count out.
// Optional feature: define GAME_CTRL_DEATH_CNT_EN to build the saturating death counter;
// otherwise death_count is tied to zero.
module game_flow_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_W      = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int TIMER_W      = 8
) (
  input  logic           Clk,
  input  logic           Reset_n,
  game_flow_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_DYING   = 3'd2,
    S_RESPAWN = 3'd3,
    S_OVER    = 3'd4,
    S_WIN     = 3'd5
  } state_t;

  localparam logic [LIVES_W-1:0] L_INIT = LIVES_W'(LIVES_INIT);
  localparam logic [LIVES_W-1:0] L_ONE  = LIVES_W'(1);
  localparam logic [TIMER_W-1:0] T_INIT = TIMER_W'(DEATH_FRAMES);
  localparam logic [TIMER_W-1:0] T_ONE  = TIMER_W'(1);

  state_t             r_state;
  logic [LIVES_W-1:0] r_lives;
  logic [TIMER_W-1:0] r_timer;
  logic               r_fr_q1, r_fr_q2;
  logic               r_chk_prev;
  logic               r_dead, r_check, r_restart;
  logic               w_fr_edge;
  logic               w_die;

  // frame_clk is asynchronous-ish to Clk; the edge shows up one Clk after it is sampled high.
  assign w_fr_edge = r_fr_q1 & ~r_fr_q2;
  // Goal wins over hazard in the same cycle, so a death needs goal low.
  assign w_die     = (r_state == S_PLAY) & ~bus.goal_hit & bus.hazard_hit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_lives    <= L_INIT;
      r_timer    <= '0;
      r_fr_q1    <= 1'b0;
      r_fr_q2    <= 1'b0;
      r_chk_prev <= 1'b0;
      r_dead     <= 1'b0;
      r_check    <= 1'b0;
      r_restart  <= 1'b0;
    end else begin
      r_fr_q1    <= bus.frame_clk;
      r_fr_q2    <= r_fr_q1;
      // History tracks in every state so a checkpoint already underfoot on entry gives no pulse.
      r_chk_prev <= bus.checkpoint_hit;
      r_dead     <= 1'b0;
      r_check    <= 1'b0;
      r_restart  <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER, S_WIN: begin
          if (bus.start) begin
            r_state   <= S_PLAY;
            r_lives   <= L_INIT;
            r_restart <= 1'b1;
          end
        end
        S_PLAY: begin
          if (bus.goal_hit) begin
            r_state <= S_WIN;
          end else if (bus.hazard_hit) begin
            r_state <= S_DYING;
            r_dead  <= 1'b1;
            r_timer <= T_INIT;
          end else if (bus.checkpoint_hit && !r_chk_prev) begin
            r_check <= 1'b1;
          end
        end
        S_DYING: begin
          if (w_fr_edge) begin
            if (r_timer == T_ONE) begin
              r_timer <= '0;
              // <= 1 also covers a zero-life misconfiguration without wrapping.
              if (r_lives <= L_ONE) begin
                r_lives <= '0;
                r_state <= S_OVER;
              end else begin
                r_lives   <= r_lives - L_ONE;
                r_state   <= S_RESPAWN;
                r_restart <= 1'b1;
              end
            end else begin
              r_timer <= r_timer - T_ONE;
            end
          end
        end
        S_RESPAWN: r_state <= S_PLAY;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

`ifdef GAME_CTRL_DEATH_CNT_EN
  logic [7:0] r_dcnt;
  // Lifetime statistic: start does not clear it, only Reset_n.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                     r_dcnt <= 8'd0;
    else if (w_die && r_dcnt != 8'hFF) r_dcnt <= r_dcnt + 8'd1;
  end
  assign bus.death_count = r_dcnt;
`else
  assign bus.death_count = 8'd0;
`endif

  assign bus.dead       = r_dead;
  assign bus.check      = r_check;
  assign bus.restart    = r_restart;
  assign bus.freeze     = (r_state != S_PLAY);
  assign bus.lives      = r_lives;
  assign bus.game_state = r_state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios followed by randomized stimulus, every cycle
// compared against a behavioural model of the game rules.
module tb_game_flow_ctrl;

  localparam int LI = 3;
  localparam int DF = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_flow_ctrl_if #(.LIVES_W(3)) bus ();

  game_flow_ctrl #(.LIVES_INIT(LI), .LIVES_W(3), .DEATH_FRAMES(DF), .TIMER_W(8)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model of the game rules: 0 IDLE,1 PLAY,2 DYING,3 RESPAWN,4 OVER,5 WIN
  int m_st, m_lives, m_timer, m_dc;
  bit m_dead, m_check, m_restart;
  bit m_f1, m_f2, m_cprev;
  int n_check;

`ifdef GAME_CTRL_DEATH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_lives = LI; m_timer = 0; m_dc = 0;
    m_dead = 0; m_check = 0; m_restart = 0;
    m_f1 = 0; m_f2 = 0; m_cprev = 0;
  endtask

  // One Clk of the rules, using the inputs present at the rising edge.
  task automatic model_step();
    bit fedge;
    fedge = m_f1 & ~m_f2;
    m_f2 = m_f1; m_f1 = bus.frame_clk;
    m_dead = 0; m_check = 0; m_restart = 0;
    if (m_st == 0 || m_st == 4 || m_st == 5) begin
      if (bus.start) begin m_st = 1; m_lives = LI; m_restart = 1; end
    end else if (m_st == 1) begin
      if (bus.goal_hit) m_st = 5;
      else if (bus.hazard_hit) begin
        m_st = 2; m_dead = 1; m_timer = DF;
        if (CNT_EN && m_dc < 255) m_dc++;
      end else if (bus.checkpoint_hit && !m_cprev) m_check = 1;
    end else if (m_st == 2) begin
      if (fedge) begin
        m_timer--;
        if (m_timer == 0) begin
          if (m_lives <= 1) begin m_lives = 0; m_st = 4; end
          else begin m_lives--; m_st = 3; m_restart = 1; end
        end
      end
    end else if (m_st == 3) m_st = 1;
    m_cprev = bus.checkpoint_hit;
  endtask

  task automatic compare_all();
    chk("state",   int'(bus.game_state),  m_st);
    chk("lives",   int'(bus.lives),       m_lives);
    chk("dead",    int'(bus.dead),        int'(m_dead));
    chk("check",   int'(bus.check),       int'(m_check));
    chk("restart", int'(bus.restart),     int'(m_restart));
    chk("freeze",  int'(bus.freeze),      int'(m_st != 1));
    chk("dcount",  int'(bus.death_count), m_dc);
  endtask

  // Inputs change on the falling edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (bus.check) n_check++;
  endtask

  task automatic clear_in();
    bus.start = 0; bus.hazard_hit = 0; bus.checkpoint_hit = 0; bus.goal_hit = 0;
  endtask

  // Kill the player once from PLAY and run frames until DYING ends.
  task automatic die();
    int guard;
    guard = 0;
    while (m_st != 1 && guard < 10) begin
      bus.start = (m_st != 3); tick(); bus.start = 0; guard++;
    end
    bus.hazard_hit = 1; tick(); bus.hazard_hit = 0;
    guard = 0;
    while (m_st == 2 && guard < 400) begin
      bus.frame_clk = ~bus.frame_clk; tick(); guard++;
    end
    if (guard >= 400) chk("dying_timeout", guard, 0);
  endtask

  initial begin
    int g;
    clear_in(); bus.frame_clk = 0;
    model_reset();
    n_check = 0;
    #12;
    compare_all();
    chk("rst_state", int'(bus.game_state), 0);
    chk("rst_freeze", int'(bus.freeze), 1);
    @(negedge clk); rst_n = 1;

    // 1: start
    bus.start = 1; tick(); bus.start = 0;
    chk("t1_restart", int'(bus.restart), 1);
    chk("t1_state", int'(bus.game_state), 1);
    chk("t1_lives", int'(bus.lives), 3);
    chk("t1_freeze", int'(bus.freeze), 0);
    tick();
    chk("t1_restart_off", int'(bus.restart), 0);

    // 2: one death, respawn
    bus.hazard_hit = 1; tick(); bus.hazard_hit = 0;
    chk("t2_dead", int'(bus.dead), 1);
    chk("t2_state", int'(bus.game_state), 2);
    g = 0;
    while (int'(bus.game_state) == 2 && g < 400) begin
      bus.frame_clk = ~bus.frame_clk; tick(); g++;
    end
    chk("t2_resp_state", int'(bus.game_state), 3);
    chk("t2_resp_restart", int'(bus.restart), 1);
    tick();
    chk("t2_play", int'(bus.game_state), 1);
    chk("t2_lives", int'(bus.lives), 2);

    // 3: checkpoint held, then re-raised
    n_check = 0;
    bus.checkpoint_hit = 1;
    repeat (500) tick();
    chk("t3_one_pulse", n_check, 1);
    bus.checkpoint_hit = 0; tick();
    bus.checkpoint_hit = 1; tick();
    chk("t3_second", int'(bus.check), 1);
    bus.checkpoint_hit = 0; tick();

    // 4: goal beats hazard and checkpoint
    bus.goal_hit = 1; bus.hazard_hit = 1; bus.checkpoint_hit = 1; tick(); clear_in();
    chk("t4_state", int'(bus.game_state), 5);
    chk("t4_dead", int'(bus.dead), 0);
    chk("t4_check", int'(bus.check), 0);
    chk("t4_freeze", int'(bus.freeze), 1);
    tick();

    // 5: game over from three lives
    bus.start = 1; tick(); bus.start = 0;
    die(); die(); die();
    chk("t5_over", int'(bus.game_state), 4);
    chk("t5_lives", int'(bus.lives), 0);
    chk("t5_norestart", int'(bus.restart), 0);
    bus.start = 1; tick(); bus.start = 0;
    chk("t5_restart", int'(bus.restart), 1);
    chk("t5_lives_reload", int'(bus.lives), 3);

    // 6: reset mid-DYING, then death counter saturation
    bus.hazard_hit = 1; tick(); bus.hazard_hit = 0;
    g = 0;
    while (m_timer > 30 && g < 400) begin
      bus.frame_clk = ~bus.frame_clk; tick(); g++;
    end
    chk("t6_timer_reached", m_timer, 30);
    rst_n = 0; model_reset(); bus.frame_clk = 0;
    #1;
    compare_all();
    chk("t6_idle", int'(bus.game_state), 0);
    chk("t6_norestart", int'(bus.restart), 0);
    chk("t6_dcount", int'(bus.death_count), 0);
    @(negedge clk); rst_n = 1;
    repeat (300) die();
    chk("t6_dcount_sat", int'(bus.death_count), CNT_EN ? 255 : 0);

    // Randomized phase
    rst_n = 0; model_reset(); clear_in(); bus.frame_clk = 0;
    #1; compare_all();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 6000; i++) begin
      bus.frame_clk      = ($urandom_range(0, 3) == 0) ? ~bus.frame_clk : bus.frame_clk;
      bus.start          = ($urandom_range(0, 19) == 0);
      bus.hazard_hit     = ($urandom_range(0, 59) == 0);
      bus.goal_hit       = ($urandom_range(0, 299) == 0);
      bus.checkpoint_hit = ($urandom_range(0, 5) == 0) ? ~bus.checkpoint_hit : bus.checkpoint_hit;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
